mpsoc_apb2ahb3_bridge: RTL

APB slave to AHB3-Lite single-master bridge: accepts one APB access at a time and replays it as a single AHB3-Lite transfer (SINGLE burst, NONSEQ). It is the reverse of the existing AHB3-to-APB peripheral bridge. It lets APB-side agents (debug or configuration masters) reach AHB memory and peripherals. Single clock domain; no synchronizers.

---
 rtl/mpsoc_apb2ahb3_pkg.sv | 37 +++
 rtl/mpsoc_apb2ahb3_bridge_if.sv | 64 ++++++
 rtl/mpsoc_apb2ahb3_strb_decode.sv | 42 ++++
 rtl/mpsoc_apb2ahb3_bridge.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mpsoc_apb2ahb3_pkg.sv
// ---------------------------------------------------------------------------
// mpsoc_apb2ahb3_pkg
// Shared types and constants for the APB-slave to AHB3-Lite-master bridge:
//   - state_t            : bridge FSM states
//   - HTRANS_* / HSIZE_* : AHB3-Lite encodings used by the bridge
//   - HBURST_SINGLE      : the only burst type the bridge issues
// Optional feature macro: APB2AHB_TIMEOUT_EN adds the DRAIN state.
// ---------------------------------------------------------------------------
package mpsoc_apb2ahb3_pkg;

`ifdef APB2AHB_TIMEOUT_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        DATA  = 3'd2,
        RESP  = 3'd3
    } state_t;
`endif

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage

// File: rtl/mpsoc_apb2ahb3_bridge_if.sv
// ---------------------------------------------------------------------------
// Bus interfaces for mpsoc_apb2ahb3_bridge.
//   mpsoc_apb2ahb3_apb_if : APB bus (PSEL, PENABLE, PWRITE, PPROT, PSTRB,
//                           PADDR, PWDATA, PRDATA, PREADY, PSLVERR)
//       modport master : drives the request, receives the response
//       modport slave  : the bridge side
//   mpsoc_apb2ahb3_ahb_if : AHB3-Lite bus (HADDR, HWDATA, HRDATA, HWRITE,
//                           HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
//                           HRESP)
//       modport master : the bridge side
//       modport slave  : memory / peripheral side
// ---------------------------------------------------------------------------
interface mpsoc_apb2ahb3_apb_if #(
    parameter int PADDR_SIZE = 16,
    parameter int PDATA_SIZE = 32
);
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [2:0]              PPROT;
    logic [PDATA_SIZE/8-1:0] PSTRB;
    logic [PADDR_SIZE-1:0]   PADDR;
    logic [PDATA_SIZE-1:0]   PWDATA;
    logic [PDATA_SIZE-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PPROT, PSTRB, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PPROT, PSTRB, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

interface mpsoc_apb2ahb3_ahb_if #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
);
    logic [HADDR_SIZE-1:0] HADDR;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic                  HREADY;
    logic                  HRESP;

    modport master (
        output HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/mpsoc_apb2ahb3_strb_decode.sv
// ---------------------------------------------------------------------------
// mpsoc_apb2ahb3_strb_decode
// Combinational map from APB write strobes to an AHB transfer shape.
//   pwrite  in  : access direction (reads are always full-word)
//   pstrb   in  : APB byte strobes
//   hsize   out : AHB transfer size
//   lane    out : HADDR[1:0] for the transfer
//   illegal out : strobe pattern has no single AHB equivalent
//   no_xfer out : write with no strobes; complete without touching AHB
// ---------------------------------------------------------------------------
module mpsoc_apb2ahb3_strb_decode
    import mpsoc_apb2ahb3_pkg::*;
(
    input  logic       pwrite,
    input  logic [3:0] pstrb,
    output logic [2:0] hsize,
    output logic [1:0] lane,
    output logic       illegal,
    output logic       no_xfer
);

    always_comb begin
        hsize   = HSIZE_WORD;
        lane    = 2'b00;
        illegal = 1'b0;
        no_xfer = 1'b0;
        if (pwrite) begin
            case (pstrb)
                4'b0000: no_xfer = 1'b1;
                4'b1111: hsize   = HSIZE_WORD;
                4'b0001: begin hsize = HSIZE_BYTE; lane = 2'd0; end
                4'b0010: begin hsize = HSIZE_BYTE; lane = 2'd1; end
                4'b0100: begin hsize = HSIZE_BYTE; lane = 2'd2; end
                4'b1000: begin hsize = HSIZE_BYTE; lane = 2'd3; end
                4'b0011: begin hsize = HSIZE_HALF; lane = 2'd0; end
                4'b1100: begin hsize = HSIZE_HALF; lane = 2'd2; end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mpsoc_apb2ahb3_bridge.sv
// ---------------------------------------------------------------------------
// mpsoc_apb2ahb3_bridge
// APB slave that replays each access as one AHB3-Lite SINGLE/NONSEQ transfer.
//   HCLK   in : clock
//   HRESET in : synchronous active-high reset
//   apb       : APB slave port  (mpsoc_apb2ahb3_apb_if.slave)
//   ahb       : AHB master port (mpsoc_apb2ahb3_ahb_if.master)
// All outputs are registered. Zero-wait AHB gives two APB wait states.
// Optional macro APB2AHB_TIMEOUT_EN: bounds the data phase to TIMEOUT cycles,
// then answers PSLVERR and drains the stuck AHB transfer before new work.
// ---------------------------------------------------------------------------
module mpsoc_apb2ahb3_bridge
    import mpsoc_apb2ahb3_pkg::*;
#(
    parameter int                    HADDR_SIZE = 32,
    parameter int                    HDATA_SIZE = 32,
    parameter int                    PADDR_SIZE = 16,
    parameter int                    PDATA_SIZE = 32,
    parameter logic [HADDR_SIZE-1:0] HADDR_BASE = '0,
    parameter int                    TIMEOUT    = 255
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    mpsoc_apb2ahb3_apb_if.slave  apb,
    mpsoc_apb2ahb3_ahb_if.master ahb
);

    state_t                  state_reg, state_next;
    logic [HADDR_SIZE-1:0]   haddr_reg, haddr_next;
    logic [HDATA_SIZE-1:0]   hwdata_reg, hwdata_next;
    logic                    hwrite_reg, hwrite_next;
    logic [2:0]              hsize_reg, hsize_next;
    logic [3:0]              hprot_reg, hprot_next;
    logic [1:0]              htrans_reg, htrans_next;
    logic [PDATA_SIZE-1:0]   prdata_reg, prdata_next;
    logic                    pready_reg, pready_next;
    logic                    pslverr_reg, pslverr_next;

    logic [2:0]              dec_hsize;
    logic [1:0]              dec_lane;
    logic                    dec_illegal;
    logic                    dec_no_xfer;
    logic                    setup;
    logic [HADDR_SIZE-1:0]   haddr_new;

    // PPROT[1] (secure/non-secure) has no AHB3-Lite counterpart.
    logic                    unused_pprot1;
    assign unused_pprot1 = apb.PPROT[1];

    mpsoc_apb2ahb3_strb_decode u_strb_decode (
        .pwrite  (apb.PWRITE),
        .pstrb   (apb.PSTRB),
        .hsize   (dec_hsize),
        .lane    (dec_lane),
        .illegal (dec_illegal),
        .no_xfer (dec_no_xfer)
    );

    assign haddr_new = HADDR_BASE | HADDR_SIZE'({apb.PADDR[PADDR_SIZE-1:2], dec_lane});

`ifdef APB2AHB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             timed_out_reg, timed_out_next;
    logic             stall_reg, stall_next;

    // A setup that arrived while draining has already moved on to its
    // access phase (PENABLE=1); stall_reg lets IDLE still pick it up.
    assign setup = apb.PSEL & (~apb.PENABLE | stall_reg);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cnt_reg       <= '0;
            timed_out_reg <= 1'b0;
            stall_reg     <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            timed_out_reg <= timed_out_next;
            stall_reg     <= stall_next;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;

    assign setup = apb.PSEL & ~apb.PENABLE;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg   <= IDLE;
            haddr_reg   <= '0;
            hwdata_reg  <= '0;
            hwrite_reg  <= 1'b0;
            hsize_reg   <= HSIZE_WORD;
            hprot_reg   <= 4'b0000;
            htrans_reg  <= HTRANS_IDLE;
            prdata_reg  <= '0;
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            haddr_reg   <= haddr_next;
            hwdata_reg  <= hwdata_next;
            hwrite_reg  <= hwrite_next;
            hsize_reg   <= hsize_next;
            hprot_reg   <= hprot_next;
            htrans_reg  <= htrans_next;
            prdata_reg  <= prdata_next;
            pready_reg  <= pready_next;
            pslverr_reg <= pslverr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        haddr_next   = haddr_reg;
        hwdata_next  = hwdata_reg;
        hwrite_next  = hwrite_reg;
        hsize_next   = hsize_reg;
        hprot_next   = hprot_reg;
        htrans_next  = HTRANS_IDLE;
        prdata_next  = prdata_reg;
        pready_next  = 1'b0;
        pslverr_next = 1'b0;
`ifdef APB2AHB_TIMEOUT_EN
        cnt_next       = cnt_reg;
        timed_out_next = timed_out_reg;
        stall_next     = stall_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (setup) begin
`ifdef APB2AHB_TIMEOUT_EN
                    stall_next = 1'b0;
`endif
                    if (dec_illegal || dec_no_xfer) begin
                        // Answer immediately; the AHB bus is not touched.
                        state_next   = RESP;
                        pready_next  = 1'b1;
                        pslverr_next = dec_illegal;
                    end else begin
                        state_next  = ADDR;
                        htrans_next = HTRANS_NONSEQ;
                        haddr_next  = haddr_new;
                        hwrite_next = apb.PWRITE;
                        hsize_next  = dec_hsize;
                        hprot_next  = {2'b00, apb.PPROT[0], ~apb.PPROT[2]};
                        // Write data goes out unchanged on every lane.
                        if (apb.PWRITE) begin
                            hwdata_next = HDATA_SIZE'(apb.PWDATA);
                        end
                    end
                end
            end
            ADDR: begin
                if (ahb.HREADY) begin
                    state_next = DATA;
`ifdef APB2AHB_TIMEOUT_EN
                    cnt_next   = '0;
`endif
                end else begin
                    htrans_next = HTRANS_NONSEQ;
                end
            end
            DATA: begin
                // The first cycle of an ERROR response has HREADY=0 and is
                // just another wait; HRESP is taken on the completing cycle.
                if (ahb.HREADY) begin
                    state_next   = RESP;
                    pready_next  = 1'b1;
                    pslverr_next = ahb.HRESP;
                    if (!hwrite_reg) begin
                        prdata_next = PDATA_SIZE'(ahb.HRDATA);
                    end
                end
`ifdef APB2AHB_TIMEOUT_EN
                else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    state_next     = RESP;
                    pready_next    = 1'b1;
                    pslverr_next   = 1'b1;
                    timed_out_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
`endif
            end
            RESP: begin
                state_next = IDLE;
`ifdef APB2AHB_TIMEOUT_EN
                // The abandoned data phase may finish during this very cycle.
                if (timed_out_reg) begin
                    timed_out_next = 1'b0;
                    if (!ahb.HREADY) begin
                        state_next = DRAIN;
                    end
                end
`endif
            end
`ifdef APB2AHB_TIMEOUT_EN
            DRAIN: begin
                if (apb.PSEL) begin
                    stall_next = 1'b1;
                end
                if (ahb.HREADY) begin
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    assign ahb.HADDR     = haddr_reg;
    assign ahb.HWDATA    = hwdata_reg;
    assign ahb.HWRITE    = hwrite_reg;
    assign ahb.HSIZE     = hsize_reg;
    assign ahb.HBURST    = HBURST_SINGLE;
    assign ahb.HPROT     = hprot_reg;
    assign ahb.HTRANS    = htrans_reg;
    assign ahb.HMASTLOCK = 1'b0;
    assign apb.PRDATA    = prdata_reg;
    assign apb.PREADY    = pready_reg;
    assign apb.PSLVERR   = pslverr_reg;

endmodule
